knn_button_ctrl: RTL and testbench
==================================

# knn_button_ctrl

Front-panel command responder for the kNN classifier top. It synchronises and debounces the four push-buttons, then captures the 8-bit switch value into the query X (age) or query Y (heart rate − 100) register. It toggles the neighbour count K between 3 and 5 and issues a single-cycle start to the kNN engine, tracking the engine's running flag until the inference completes. It sits between the board I/O pins and the engine inside `top`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised cycles required to accept a level change. Board build overrides this to 1_000_000.
- `ACK_TIMEOUT`, default 16: cycles allowed after `start` for `engine_running` to rise.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `switches` in 8: operand / value input.
- `btn_load_x`, `btn_load_y`, `btn_start`, `btn_toggle_k` in 1 each: raw asynchronous buttons, active-high.
- `engine_running` in 1: engine busy flag.
- `query_x` out 8: captured X.
- `query_y` out 8: captured Y.
- `k_is_five` out 1: 0 means K=3, 1 means K=5.
- `start` out 1: one-cycle engine start pulse.
- `busy` out 1: high in every state except IDLE.
- `x_valid`, `y_valid` out 1 each: operand has been loaded since reset.
- `reject` out 1: sticky flag set by an ignored start; cleared by the next accepted start.
- `ack_error` out 1: sticky flag set by an engine acknowledge timeout; cleared by the next accepted start.

## Operation
- **Per-button front end:** 2-flop synchroniser, then debouncer, then rising-edge detector.
  - The debouncer counts cycles where the synchronised level differs from the debounced level. The count resets whenever they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips.
  - A debounced 0→1 transition produces one `evt_*` pulse. Releases produce nothing.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles are ignored.
- **Event actions in IDLE:**
  - `evt_load_x`: `query_x` ← `switches`, `x_valid` ← 1.
  - `evt_load_y`: `query_y` ← `switches`, `y_valid` ← 1.
  - `evt_toggle_k`: `k_is_five` ← ~`k_is_five`.
  - Switch value is sampled in the same cycle as the event. There is no arithmetic on operands; the offset of 100 is applied by the operator.
- **Simultaneous events:** `evt_start` has priority, and any load/toggle events in the same cycle are dropped. Simultaneous load/toggle events without a start are all applied, since they target independent registers.
- **Events outside IDLE:** load and toggle events are ignored, so operands stay frozen during inference. A start event sets `reject`.
- **FSM states:**
  - IDLE:
    - `evt_start` with `x_valid & y_valid` → LAUNCH, clearing `reject` and `ack_error`.
    - `evt_start` with either operand invalid sets `reject` and stays in IDLE.
  - LAUNCH: `start`=1 for exactly this cycle → WAIT_ACK. The timeout counter is cleared.
  - WAIT_ACK:
    - `engine_running`=1 → RUN.
    - After `ACK_TIMEOUT` cycles without it → IDLE with `ack_error` ← 1.
  - RUN: `engine_running`=0 → IDLE.
- The timeout counter is `$clog2(ACK_TIMEOUT+1)` bits and saturates. The debounce counter is `$clog2(DEBOUNCE_CYCLES+1)` bits.

## Timing
- **Reset values:**
  - `query_x`=0, `query_y`=0, `k_is_five`=0, `start`=0, `busy`=0.
  - `x_valid`=0, `y_valid`=0, `reject`=0, `ack_error`=0.
  - FSM is in IDLE. Synchroniser flops, debounced levels and counters are 0.
- **Press latency:** a raw press first sampled at edge t0 produces its registered effect at edge t0+`DEBOUNCE_CYCLES`+3.
  - This covers 2 synchroniser cycles, `DEBOUNCE_CYCLES` stable cycles, and 1 cycle for the event register.
  - The effect is the operand/K update, or entry to LAUNCH.
  - `start` is high during the cycle after LAUNCH entry.
- **Minimum accepted press:** `DEBOUNCE_CYCLES`+1 cycles. A 100 ns press (10 cycles at 100 MHz) is accepted with the default parameter.
- **`busy`:** rises on the same edge that enters LAUNCH. It falls on the edge after `engine_running` is sampled low in RUN.
- **Reset mid-operation:** all state returns to reset values at the next edge and `start` is never emitted.
  - A button still held at reset release is seen as a fresh press.
  - It fires its event `DEBOUNCE_CYCLES`+3 edges after reset deasserts.
- **Held button:** produces exactly one event. A new event requires a debounced release followed by a new press.
- **Engine behaviour:**
  - If `engine_running` rises and falls while the FSM is in LAUNCH, that pulse is missed and the FSM times out. This is acceptable, since the engine raises running no earlier than one cycle after `start`.
  - If `engine_running` is already high in WAIT_ACK, the FSM enters RUN immediately.

## Test plan
- **Load X:** `switches`=0x3F, press `btn_load_x` for 10 cycles → `query_x`=0x3F and `x_valid`=1 at press+7 edges; `query_y` stays 0.
- **Load Y and toggle K:** load Y with `switches`=0xD2 (0x36−100 mod 256), then toggle with `switches`=1 → `query_y`=0xD2 and `k_is_five`=1. A second toggle press returns `k_is_five` to 0.
- **Full inference:** after X and Y are loaded, press start. Model the engine to raise running 2 cycles after `start` for 40 cycles. Expect:
  - exactly one `start` pulse;
  - `busy` high throughout;
  - `busy` low 1 cycle after running falls;
  - `reject`=0 and `ack_error`=0.
- **Frozen operands and early start:**
  - During RUN, pressing load_x with `switches`=0x55 leaves `query_x`=0x3F; pressing start sets `reject`=1 with no second pulse.
  - After reset, pressing start with only X loaded sets `reject`=1 and produces no `start`.
- **Glitch, timeout and reset:**
  - A 3-cycle glitch on `btn_start` produces no event.
  - An engine that never raises running gives `ack_error`=1 and IDLE 16 cycles after WAIT_ACK entry.
  - Asserting reset while in RUN sets all outputs to 0 on the next edge.

Source files
------------

// File: rtl/knn_button_ctrl.sv
// -----------------------------------------------------------------------------
// knn_button_ctrl
//
// Front-panel command responder for the kNN classifier. Each of the four raw
// push-buttons passes through a 2-flop synchroniser, a counting debouncer and
// a rising-edge detector to produce a single-cycle event. Events load the
// query operands from the switches, toggle K between 3 and 5, or launch an
// inference. The launch FSM issues a one-cycle start and follows the engine's
// running flag until the inference completes.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   switches[7:0]   : operand value sampled on load events
//   btn_load_x      : raw button, capture switches into query_x
//   btn_load_y      : raw button, capture switches into query_y
//   btn_start       : raw button, launch an inference
//   btn_toggle_k    : raw button, toggle K between 3 and 5
//   engine_running  : engine busy flag
//   query_x/query_y : captured operands
//   k_is_five       : 0 -> K=3, 1 -> K=5
//   start           : one-cycle engine start pulse
//   busy            : high whenever the FSM is not idle
//   x_valid/y_valid : operand loaded since reset
//   reject          : sticky, a start event was ignored
//   ack_error       : sticky, engine never acknowledged a start
// -----------------------------------------------------------------------------
module knn_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] switches,
  input  logic       btn_load_x,
  input  logic       btn_load_y,
  input  logic       btn_start,
  input  logic       btn_toggle_k,
  input  logic       engine_running,
  output logic [7:0] query_x,
  output logic [7:0] query_y,
  output logic       k_is_five,
  output logic       start,
  output logic       busy,
  output logic       x_valid,
  output logic       y_valid,
  output logic       reject,
  output logic       ack_error
);

  localparam int NB  = 4;
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TCW = $clog2(ACK_TIMEOUT + 1);

  // Bit positions of the buttons inside the per-button vectors.
  localparam int B_X     = 0;
  localparam int B_Y     = 1;
  localparam int B_START = 2;
  localparam int B_K     = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_RUN
  } state_e;

  logic [NB-1:0] btn_raw;
  assign btn_raw = {btn_toggle_k, btn_start, btn_load_y, btn_load_x};

  // ---------------------------------------------------------------------------
  // Button front end
  // ---------------------------------------------------------------------------
  logic [NB-1:0]  sync1_q, sync1_d;
  logic [NB-1:0]  sync2_q, sync2_d;
  logic [NB-1:0]  deb_q, deb_d;
  logic [NB-1:0]  evt_q, evt_d;
  logic [DCW-1:0] cnt_q [NB];
  logic [DCW-1:0] cnt_d [NB];

  // NOTE: every signal written in an always_comb block gets a default value
  // before any conditional assignment, so no path can leave it unassigned and
  // infer a latch.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    evt_d   = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        // The counter holds DEBOUNCE_CYCLES once the level has differed that
        // long; the flip happens on the next differing sample, so an accepted
        // press needs DEBOUNCE_CYCLES+1 consecutive samples.
        if (cnt_q[i] == DCW'(DEBOUNCE_CYCLES)) begin
          deb_d[i] = sync2_q[i];
          evt_d[i] = sync2_q[i];  // only the 0->1 flip is an event
        end else begin
          cnt_d[i] = cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM and operand registers
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [7:0]     query_x_q, query_x_d;
  logic [7:0]     query_y_q, query_y_d;
  logic           k_is_five_q, k_is_five_d;
  logic           start_q, start_d;
  logic           busy_q, busy_d;
  logic           x_valid_q, x_valid_d;
  logic           y_valid_q, y_valid_d;
  logic           reject_q, reject_d;
  logic           ack_error_q, ack_error_d;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    query_x_d   = query_x_q;
    query_y_d   = query_y_q;
    k_is_five_d = k_is_five_q;
    x_valid_d   = x_valid_q;
    y_valid_d   = y_valid_q;
    reject_d    = reject_q;
    ack_error_d = ack_error_q;

    unique case (state_q)
      S_IDLE: begin
        if (evt_q[B_START]) begin
          // Start wins; load/toggle events in the same cycle are dropped.
          if (x_valid_q && y_valid_q) begin
            state_d     = S_LAUNCH;
            reject_d    = 1'b0;
            ack_error_d = 1'b0;
          end else begin
            reject_d = 1'b1;
          end
        end else begin
          // Independent registers, so simultaneous events all apply.
          if (evt_q[B_X]) begin
            query_x_d = switches;
            x_valid_d = 1'b1;
          end
          if (evt_q[B_Y]) begin
            query_y_d = switches;
            y_valid_d = 1'b1;
          end
          if (evt_q[B_K]) begin
            k_is_five_d = ~k_is_five_q;
          end
        end
      end

      S_LAUNCH: begin
        state_d = S_WAIT_ACK;
        tmo_d   = '0;
      end

      S_WAIT_ACK: begin
        if (engine_running) begin
          state_d = S_RUN;
        end else if (tmo_q >= TCW'(ACK_TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          ack_error_d = 1'b1;
        end else if (tmo_q != TCW'(ACK_TIMEOUT)) begin
          tmo_d = tmo_q + TCW'(1);
        end
      end

      S_RUN: begin
        if (!engine_running) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Operands are frozen outside IDLE; a start there is only flagged.
    if (state_q != S_IDLE && evt_q[B_START]) begin
      reject_d = 1'b1;
    end

    // Outputs are registered from the next state so they line up with it.
    start_d = (state_d == S_LAUNCH);
    busy_d  = (state_d != S_IDLE);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge regardless of
  // statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      evt_q       <= '0;
      cnt_q       <= '{default: '0};
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      query_x_q   <= '0;
      query_y_q   <= '0;
      k_is_five_q <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      x_valid_q   <= 1'b0;
      y_valid_q   <= 1'b0;
      reject_q    <= 1'b0;
      ack_error_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      evt_q       <= evt_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      query_x_q   <= query_x_d;
      query_y_q   <= query_y_d;
      k_is_five_q <= k_is_five_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      x_valid_q   <= x_valid_d;
      y_valid_q   <= y_valid_d;
      reject_q    <= reject_d;
      ack_error_q <= ack_error_d;
    end
  end

  assign query_x   = query_x_q;
  assign query_y   = query_y_q;
  assign k_is_five = k_is_five_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign x_valid   = x_valid_q;
  assign y_valid   = y_valid_q;
  assign reject    = reject_q;
  assign ack_error = ack_error_q;

endmodule

// File: tb/tb_knn_button_ctrl.sv
// -----------------------------------------------------------------------------
// tb_knn_button_ctrl
//
// Self-checking bench for knn_button_ctrl. Inputs are driven just after the
// falling edge and outputs are sampled on the falling edge. A table of button
// presses exercises loads, toggles and press-length boundaries; hand-written
// sequences cover launch, run, reject, timeout and reset behaviour; a random
// phase compares operand state against a window-based reference model.
// -----------------------------------------------------------------------------
module tb_knn_button_ctrl;

  localparam int D  = 4;
  localparam int T  = 16;
  localparam int HL = D + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] switches;
  logic [3:0] btn;              // {toggle_k, start, load_y, load_x}
  logic       engine_running;
  logic [7:0] query_x, query_y;
  logic       k_is_five, start, busy, x_valid, y_valid, reject, ack_error;

  always #5 clk = ~clk;

  knn_button_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .ACK_TIMEOUT    (T)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .switches      (switches),
    .btn_load_x    (btn[0]),
    .btn_load_y    (btn[1]),
    .btn_start     (btn[2]),
    .btn_toggle_k  (btn[3]),
    .engine_running(engine_running),
    .query_x       (query_x),
    .query_y       (query_y),
    .k_is_five     (k_is_five),
    .start         (start),
    .busy          (busy),
    .x_valid       (x_valid),
    .y_valid       (y_valid),
    .reject        (reject),
    .ack_error     (ack_error)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    cyc(hold);
    btn[b] = 1'b0;
  endtask

  // Waits for the start pulse; buttons are released after release_at cycles.
  task automatic wait_start(input int limit, input int release_at, output int when);
    when = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc(1);
      if (i == release_at) btn = '0;
      if (start === 1'b1) begin
        when = i;
        break;
      end
    end
    btn = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitors, sampled well after the rising edge
  // ---------------------------------------------------------------------------
  int start_cnt = 0;
  int busy_drop = 0;
  bit mon_busy  = 1'b0;

  always @(posedge clk) begin
    #2;
    if (start === 1'b1) start_cnt++;
    if (mon_busy && busy !== 1'b1) busy_drop++;
  end

  // ---------------------------------------------------------------------------
  // Reference model for the operand registers (no start activity assumed).
  // A level is accepted once the last D+1 synchronised samples all disagree
  // with the current accepted level; synchronised samples lag the raw pin by
  // two edges, and an accepted rise acts one edge later.
  // ---------------------------------------------------------------------------
  logic [7:0] m_qx, m_qy;
  logic       m_k, m_xv, m_yv;
  bit         hist [4][HL];
  bit         lvl  [4];
  bit         pend [4];
  bit         stable;

  always @(posedge clk) begin
    if (reset) begin
      m_qx = '0; m_qy = '0; m_k = 1'b0; m_xv = 1'b0; m_yv = 1'b0;
      for (int b = 0; b < 4; b++) begin
        lvl[b]  = 1'b0;
        pend[b] = 1'b0;
        for (int k = 0; k < HL; k++) hist[b][k] = 1'b0;
      end
    end else begin
      if (pend[0]) begin m_qx = switches; m_xv = 1'b1; end
      if (pend[1]) begin m_qy = switches; m_yv = 1'b1; end
      if (pend[3]) m_k = ~m_k;
      for (int b = 0; b < 4; b++) begin
        for (int k = HL - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = btn[b];
        stable = 1'b1;
        for (int k = 2; k < HL; k++) if (hist[b][k] == lvl[b]) stable = 1'b0;
        pend[b] = 1'b0;
        if (stable) begin
          lvl[b]  = ~lvl[b];
          pend[b] = lvl[b];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press table
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    int         b;
    logic [7:0] sw;
    int         hold;
    logic [7:0] qx, qy;
    logic       k, xv, yv;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int when;
    int sb, bb;
    logic [7:0] mask;
    int hold, gap;

    //               name          b  sw     hold qx     qy     k  xv yv
    vecs[0] = '{"load_y",        1, 8'hD2, 10, 8'h3F, 8'hD2, 0, 1, 1};
    vecs[1] = '{"toggle_k_1",    3, 8'h01, 10, 8'h3F, 8'hD2, 1, 1, 1};
    vecs[2] = '{"toggle_k_2",    3, 8'h01, 10, 8'h3F, 8'hD2, 0, 1, 1};
    vecs[3] = '{"short_k_4",     3, 8'h00,  4, 8'h3F, 8'hD2, 0, 1, 1};
    vecs[4] = '{"min_k_5",       3, 8'h00,  5, 8'h3F, 8'hD2, 1, 1, 1};
    vecs[5] = '{"glitch_x_3",    0, 8'h11,  3, 8'h3F, 8'hD2, 1, 1, 1};
    vecs[6] = '{"min_x_5",       0, 8'hA5,  5, 8'hA5, 8'hD2, 1, 1, 1};
    vecs[7] = '{"reload_x",      0, 8'h3F, 10, 8'h3F, 8'hD2, 1, 1, 1};

    reset = 1'b1; btn = '0; switches = '0; engine_running = 1'b0;
    cyc(3);
    check("reset_outputs", {9'b0, query_x, query_y, k_is_five, start, busy, x_valid,
                            y_valid, reject, ack_error}, 32'h0);
    reset = 1'b0;
    cyc(2);
    check("idle_outputs", {9'b0, query_x, query_y, k_is_five, start, busy, x_valid,
                           y_valid, reject, ack_error}, 32'h0);

    // Load X with exact latency: effect lands on the 8th rising edge.
    switches = 8'h3F;
    btn[0] = 1'b1;
    cyc(7);
    check("x_valid_early", x_valid, 1'b0);
    cyc(1);
    check("x_valid_latency", x_valid, 1'b1);
    check("query_x_3f", query_x, 8'h3F);
    check("query_y_untouched", query_y, 8'h00);
    cyc(2);
    btn[0] = 1'b0;
    cyc(12);

    for (int i = 0; i < 8; i++) begin
      switches = vecs[i].sw;
      press(vecs[i].b, vecs[i].hold);
      cyc(12);
      check({vecs[i].name, "_qx"}, query_x, vecs[i].qx);
      check({vecs[i].name, "_qy"}, query_y, vecs[i].qy);
      check({vecs[i].name, "_k"}, k_is_five, vecs[i].k);
      check({vecs[i].name, "_xv"}, x_valid, vecs[i].xv);
      check({vecs[i].name, "_yv"}, y_valid, vecs[i].yv);
    end

    // Full inference; load_x and toggle_k pressed together with start are dropped.
    sb = start_cnt; bb = busy_drop;
    switches = 8'h99;
    btn[0] = 1'b1; btn[2] = 1'b1; btn[3] = 1'b1;
    wait_start(30, 6, when);
    check("start_latency", when, 8);
    check("busy_at_launch", busy, 1'b1);
    mon_busy = 1'b1;
    cyc(2);
    engine_running = 1'b1;
    cyc(3);
    check("dropped_load_x", query_x, 8'h3F);
    check("dropped_toggle_k", k_is_five, 1'b1);
    check("reject_after_launch", reject, 1'b0);
    check("ack_error_after_launch", ack_error, 1'b0);
    switches = 8'h55;
    press(0, 10);
    cyc(3);
    press(2, 10);
    cyc(14);
    engine_running = 1'b0;
    mon_busy = 1'b0;
    cyc(1);
    check("busy_fall", busy, 1'b0);
    cyc(1);
    check("busy_held_in_run", busy_drop - bb, 0);
    check("single_start_pulse", start_cnt - sb, 1);
    check("frozen_query_x", query_x, 8'h3F);
    check("reject_in_run", reject, 1'b1);
    check("ack_error_clean", ack_error, 1'b0);

    // Ack timeout; accepted start also clears reject.
    sb = start_cnt;
    btn[2] = 1'b1;
    wait_start(30, 6, when);
    check("timeout_start_latency", when, 8);
    check("reject_cleared", reject, 1'b0);
    cyc(16);
    check("busy_before_timeout", busy, 1'b1);
    check("ack_error_before_timeout", ack_error, 1'b0);
    cyc(1);
    check("ack_error_timeout", ack_error, 1'b1);
    check("idle_after_timeout", busy, 1'b0);
    cyc(2);
    check("timeout_one_pulse", start_cnt - sb, 1);

    // Early start with only X loaded.
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(1);
    switches = 8'h3F;
    press(0, 10);
    cyc(12);
    sb = start_cnt;
    press(2, 10);
    cyc(12);
    check("early_start_reject", reject, 1'b1);
    check("early_start_no_pulse", start_cnt - sb, 0);
    check("early_start_idle", busy, 1'b0);

    // 3-cycle glitch on start with both operands valid.
    switches = 8'hD2;
    press(1, 10);
    cyc(12);
    check("y_loaded", y_valid, 1'b1);
    sb = start_cnt;
    press(2, 3);
    cyc(12);
    check("glitch_no_start", start_cnt - sb, 0);
    check("glitch_idle", busy, 1'b0);

    // Reset while in RUN.
    press(3, 10);
    cyc(12);
    check("k_before_reset", k_is_five, 1'b1);
    btn[2] = 1'b1;
    wait_start(30, 6, when);
    check("run_start_latency", when, 8);
    cyc(2);
    engine_running = 1'b1;
    cyc(5);
    check("busy_in_run", busy, 1'b1);
    reset = 1'b1;
    btn[3] = 1'b1;
    cyc(1);
    check("reset_in_run", {9'b0, query_x, query_y, k_is_five, start, busy, x_valid,
                           y_valid, reject, ack_error}, 32'h0);
    engine_running = 1'b0;
    cyc(2);

    // Toggle held through reset release: one fresh event, then nothing.
    reset = 1'b0;
    cyc(7);
    check("held_k_early", k_is_five, 1'b0);
    cyc(1);
    check("held_k_fires", k_is_five, 1'b1);
    cyc(22);
    check("held_k_single", k_is_five, 1'b1);
    btn[3] = 1'b0;
    cyc(12);

    // Random overlapping load/toggle presses against the model.
    reset = 1'b1; cyc(2); reset = 1'b0;
    for (int it = 0; it < 80; it++) begin
      mask = 8'($urandom_range(1, 7));
      hold = $urandom_range(1, 9);
      gap  = $urandom_range(0, 9);
      for (int c = 0; c < hold; c++) begin
        switches = 8'($urandom);
        btn[0] = mask[0]; btn[1] = mask[1]; btn[3] = mask[2];
        cyc(1);
        check("rand_state", {13'b0, query_x, query_y, k_is_five, x_valid, y_valid},
              {13'b0, m_qx, m_qy, m_k, m_xv, m_yv});
      end
      btn = '0;
      for (int c = 0; c < gap; c++) begin
        switches = 8'($urandom);
        cyc(1);
        check("rand_state", {13'b0, query_x, query_y, k_is_five, x_valid, y_valid},
              {13'b0, m_qx, m_qy, m_k, m_xv, m_yv});
      end
    end
    check("rand_no_start", {start, busy, reject}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
